// File: rtl/spi_dac_mc.sv
// spi_dac_mc: multi-channel SPI master for 24-bit serial DACs sharing one SCLK/SDO bus,
// with per-channel request latching, round-robin arbitration and an enforced inter-frame gap.
module spi_dac_mc #(
    parameter int BITS      = 24,
    parameter int NCH       = 2,
    parameter int DIV       = 2,
    parameter int GAP       = 4,
    parameter bit SCLK_IDLE = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NCH*BITS-1:0] in,
    input  logic [NCH-1:0]      go,
    output logic                busy,
    output logic [NCH-1:0]      done,
    output logic [NCH-1:0]      SS_n,
    output logic                SCLK,
    output logic                SDO
);
    localparam int PW = NCH > 1 ? $clog2(NCH) : 1;
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int BW = $clog2(BITS + 1);
    localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;
    state_t          state, state_nx;
    logic [NCH-1:0]  pending, req, rot;
    logic [BITS-1:0] hold [NCH];
    logic [BITS-1:0] sh;
    logic [PW-1:0]   ptr, cur, win, ofs;
    logic [PW:0]     sum;
    logic            found, half, bit_end, last_bit, gap_end, start;
    logic [DW-1:0]   div;
    logic [BW-1:0]   bitcnt;
    logic [GW-1:0]   gcnt;

    assign req = pending | go;

    // rotate requests so the search starts at ptr, then map the offset back to a channel
    always_comb begin
        rot   = NCH'({req, req} >> ptr);
        found = 1'b0;
        ofs   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                ofs   = PW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, ofs};
        win = sum >= (PW+1)'(NCH) ? PW'(sum - (PW+1)'(NCH)) : PW'(sum);
    end

    assign bit_end  = state == ST_SHIFT && half && div == DW'(DIV - 1);
    assign last_bit = bit_end && bitcnt == BW'(BITS - 1);
    assign gap_end  = state == ST_GAP && gcnt == GW'(GAP - 1);
    assign start    = found && (state == ST_IDLE || gap_end);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = start ? ST_SHIFT : last_bit ? ST_GAP : gap_end ? ST_IDLE : state;
    end

    always_comb begin
        SS_n = state == ST_SHIFT ? ~(NCH'(1) << cur) : '1;
        SCLK = state == ST_SHIFT ? ~half : SCLK_IDLE;
        SDO  = state == ST_SHIFT && sh[BITS-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            for (int c = 0; c < NCH; c++) hold[c] <= '0;
            sh      <= '0;
            ptr     <= '0;
            cur     <= '0;
            div     <= '0;
            half    <= 1'b0;
            bitcnt  <= '0;
            gcnt    <= '0;
            done    <= '0;
            busy    <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++)
                if (go[c]) hold[c] <= in[c*BITS +: BITS];
            pending <= req & ~(start ? NCH'(1) << win : '0);
            done    <= last_bit ? NCH'(1) << cur : '0;
            busy    <= state != ST_IDLE || |req;
            gcnt    <= gap_end || state != ST_GAP ? '0 : gcnt + 1'b1;
            if (start) begin
                // a go on the winner in this same cycle carries the newest data
                sh     <= go[win] ? in[win*BITS +: BITS] : hold[win];
                cur    <= win;
                ptr    <= win == PW'(NCH - 1) ? '0 : win + 1'b1;
                div    <= '0;
                half   <= 1'b0;
                bitcnt <= '0;
            end else if (state == ST_SHIFT) begin
                div <= div == DW'(DIV - 1) ? '0 : div + 1'b1;
                if (div == DW'(DIV - 1)) half <= ~half;
                if (bit_end) begin
                    sh     <= sh << 1;
                    bitcnt <= bitcnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_dac_mc.sv
// tb_spi_dac_mc: scoreboard bench for spi_dac_mc; a timeline model predicts each frame's
// channel, data and start cycle, and a bus monitor reconstructs frames from SS_n/SCLK/SDO.
module tb_spi_dac_mc;
    localparam int BITS = 24, NCH = 2, DIV = 2, GAP = 4, FLEN = BITS * 2 * DIV;

    logic                clk = 1'b0, reset_n = 1'b1;
    logic [NCH*BITS-1:0] din = '0;
    logic [NCH-1:0]      go = '0;
    logic                busy, SCLK, SDO;
    logic [NCH-1:0]      done, SS_n;

    spi_dac_mc #(.BITS(BITS), .NCH(NCH), .DIV(DIV), .GAP(GAP), .SCLK_IDLE(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .in(din), .go(go), .busy(busy),
        .done(done), .SS_n(SS_n), .SCLK(SCLK), .SDO(SDO));

    always #5 clk = ~clk;

    typedef struct {int ch; logic [BITS-1:0] data; int start;} frame_t;
    frame_t exp_q[$];
    int tests = 0, fails = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // reference: the bus is a single server, busy for one frame plus the gap after each start
    logic [NCH-1:0]  pend = '0;
    logic [BITS-1:0] mhold [NCH];
    int              mptr = 0, free_at = 0, w;
    frame_t          f;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend = '0;
            mptr = 0;
            free_at = cyc;
            exp_q.delete();
        end else begin
            for (int c = 0; c < NCH; c++)
                if (go[c]) begin
                    pend[c] = 1'b1;
                    mhold[c] = din[c*BITS +: BITS];
                end
            if (cyc >= free_at && pend != 0) begin
                w = -1;
                for (int i = 0; i < NCH; i++)
                    if (w < 0 && pend[(mptr + i) % NCH]) w = (mptr + i) % NCH;
                f.ch = w;
                f.data = mhold[w];
                f.start = cyc;
                exp_q.push_back(f);
                pend[w] = 1'b0;
                mptr = (w + 1) % NCH;
                free_at = cyc + FLEN + GAP;
            end
        end
    end

    int              fch, flen, nb;
    logic [BITS-1:0] fdata;
    bit              in_frame = 0, prev_sclk = 1;
    always @(negedge clk) begin
        if (!reset_n) in_frame = 0;
        else begin
            check("ss_onehot", $countones(~SS_n) <= 1, 1);
            if (!in_frame && SS_n != {NCH{1'b1}}) begin
                in_frame = 1;
                flen = 0;
                nb = 0;
                fdata = '0;
                for (int c = 0; c < NCH; c++) if (!SS_n[c]) fch = c;
                if (exp_q.size() == 0) check("unexpected_frame", fch, -1);
                else begin
                    check("frame_ch", fch, exp_q[0].ch);
                    check("frame_start", cyc, exp_q[0].start + 1);
                end
            end
            if (in_frame) begin
                if (SS_n == {NCH{1'b1}}) begin
                    in_frame = 0;
                    check("frame_len", flen, FLEN);
                    check("frame_bits", nb, BITS);
                    check("done_pulse", done, 1 << fch);
                    if (exp_q.size() > 0) begin
                        check("frame_data", fdata, exp_q[0].data);
                        void'(exp_q.pop_front());
                    end
                end else begin
                    flen++;
                    if (prev_sclk && !SCLK) begin
                        fdata = {fdata[BITS-2:0], SDO};
                        nb++;
                    end
                    check("done_mid", done, 0);
                end
            end else check("done_idle", done, 0);
        end
        prev_sclk = SCLK;
    end

    task automatic tick(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(logic [NCH-1:0] m, logic [BITS-1:0] d0, logic [BITS-1:0] d1);
        @(negedge clk);
        go = m;
        din = {d1, d0};
        @(negedge clk);
        go = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0 || in_frame) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", n < 5000, 1);
        tick(3);
    endtask

    initial begin
        int n;
        #1 reset_n = 1'b0;
        tick(3);
        check("rst_ss", SS_n, 2'b11);
        check("rst_sclk", SCLK, 1);
        check("rst_sdo", SDO, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        #2 reset_n = 1'b1;
        tick(2);

        send(2'b01, 24'h85ABCD, 24'h0);
        check("t1_ss0_low", SS_n[0], 0);
        check("t1_ss1_high", SS_n[1], 1);
        n = 0;
        while (!SS_n[0] && n < 200) begin tick(); n++; end
        check("t1_ss0_rise", n < 200, 1);
        n = 0;
        while (busy && n < 20) begin tick(); n++; end
        check("t1_busy_drop", n, 5);
        wait_idle();

        send(2'b11, 24'h000123, 24'h00FFFF);
        wait_idle();

        send(2'b01, 24'h85ABCD, 24'h0);
        tick(20);
        send(2'b10, 24'h0, 24'h111111);
        tick(20);
        send(2'b10, 24'h0, 24'h222222);
        wait_idle();

        send(2'b01, 24'h85ABCD, 24'h0);
        tick(30);
        send(2'b01, 24'h0000AA, 24'h0);
        wait_idle();

        @(negedge clk);
        go = 2'b11;
        repeat (420) begin
            for (int c = 0; c < NCH; c++) din[c*BITS +: BITS] = BITS'($urandom);
            tick();
        end
        go = '0;
        wait_idle();

        repeat (600) begin
            go = ($urandom_range(0, 9) == 0) ? NCH'($urandom) : '0;
            for (int c = 0; c < NCH; c++) din[c*BITS +: BITS] = BITS'($urandom);
            tick();
        end
        go = '0;
        wait_idle();

        send(2'b01, 24'h85ABCD, 24'h0);
        tick(40);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_ss", SS_n, 2'b11);
        check("mid_rst_sclk", SCLK, 1);
        check("mid_rst_sdo", SDO, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        tick(50);
        check("post_rst_ss", SS_n, 2'b11);
        check("post_rst_busy", busy, 0);

        send(2'b10, 24'h0, 24'h5A5A5A);
        wait_idle();
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
